piece_dropper: RTL and testbench
================================

PIECE_DROPPER -- requirements
Module: piece_dropper

Interface
REQ-001 SHALL provide parameter ROWS, default 7: board rows; row 0 is the bottom row. Only 7 is supported.
REQ-002 SHALL provide parameter COLS, default 7: board columns. Only 7 is supported.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port clear, input, 1 bit: request to wipe the board; sampled only in IDLE.
REQ-006 SHALL have port drop_valid, input, 1 bit: a drop request is present.
REQ-007 SHALL have port drop_col, input, 3 bits: target column of the drop request.
REQ-008 SHALL have port drop_ready, output, 1 bit: high exactly when the state is IDLE and reset is low.
REQ-009 SHALL have port ram_address, output, 6 bits: board RAM address, computed as row*7+col.
REQ-010 SHALL have port ram_data, output, 2 bits: write data; 00 = empty, 01 = player 1, 10 = player 2.
REQ-011 SHALL have port ram_wren, output, 1 bit: RAM write enable.
REQ-012 SHALL have port ram_q, input, 2 bits: RAM read data, valid one Clk after ram_address is presented.
REQ-013 SHALL have port current_player, output, 2 bits: the player (01 or 10) who owns the next drop.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a piece has been written.
REQ-015 SHALL have port piece_row, output, 3 bits: row of the last written piece; held until the next write.
REQ-016 SHALL have port col_full, output, 1 bit: one-cycle pulse when a drop is rejected.
REQ-017 SHALL have port move_count, output, 6 bits: number of pieces written since the last clear.
REQ-018 SHALL have port board_full, output, 1 bit: high when move_count equals 49.

Function
REQ-019 SHALL implement states CLEAR, IDLE, READ, CHECK, WRITE, DONE and REJECT.
REQ-020 SHALL step through CLEAR as follows: ram_wren=1, ram_data=00, address = sweep counter 0..48, incrementing one per cycle; after address 48 the next state is IDLE.
REQ-021 SHALL set, on every CLEAR entry, current_player to 01, move_count to 0 and piece_row to 0.
REQ-022 SHALL, in IDLE with clear=1, enter CLEAR on the next cycle and ignore drop_valid that cycle (clear has priority).
REQ-023 SHALL accept a drop when drop_valid & drop_ready & ~clear are all high, and latch drop_col at that point.
REQ-024 SHALL, on an accepted drop with drop_col > 6, go to REJECT for one cycle (col_full=1) with no RAM access, then return to IDLE.
REQ-025 SHALL, on an accepted valid drop, go to READ with the scan row set to 0.
REQ-026 SHALL, in READ, drive ram_address = row*7+col with ram_wren=0, then go to CHECK.
REQ-027 SHALL, in CHECK: go to WRITE if ram_q==00; else go to REJECT if row==6; else increment row and go back to READ.
REQ-028 SHALL, in WRITE, drive ram_address = row*7+col, ram_data = current_player and ram_wren=1 for exactly one cycle.
REQ-029 SHALL, in DONE, hold done=1 and piece_row=row, toggle current_player, increment move_count, then return to IDLE.
REQ-030 SHALL meet this latency, with the accept cycle = T and the landing row = r: ram_wren at T+3+2r, done at T+4+2r, drop_ready high again at T+5+2r.
REQ-031 SHALL give full-column timing, with accept cycle T: col_full at T+15, drop_ready at T+16; current_player and move_count unchanged.
REQ-032 SHALL hold ram_wren=0 in every state except CLEAR and WRITE.
REQ-033 SHALL hold done=0 and col_full=0 in every state except DONE and REJECT respectively.
REQ-034 SHALL never wrap move_count past 49: a full board rejects every drop through the column scan.

Reset
REQ-035 SHALL, while reset=1: force the state to CLEAR with sweep counter 0, current_player=01, move_count=0, piece_row=0, and drive ram_wren=0, drop_ready=0, done=0, col_full=0, ram_address=0.
REQ-036 SHALL, on the first cycle after reset falls, write address 0 and complete the 49-cycle sweep; drop_ready rises on the 50th cycle.
REQ-037 SHALL, when reset is asserted mid-scan, mid-write or mid-clear, abandon the operation with no further writes, and restart the sweep from 0.

Verification
REQ-038 SHALL check: reset for 2 cycles, then release -> 49 consecutive writes of 00 to addresses 0..48, then drop_ready=1 and current_player=01.
REQ-039 SHALL check: empty board, drop column 3 accepted at T -> write of 01 to address 3 at T+3, done at T+4 with piece_row=0, current_player=10.
REQ-040 SHALL check: column 2 holding 3 pieces, drop at T -> reads of addresses 2, 9, 16, 23, write at T+9 to address 23, piece_row=3.
REQ-041 SHALL check: column 0 filled (7 drops), 8th drop at T -> col_full at T+15, no write, move_count stays 7, current_player unchanged.
REQ-042 SHALL check: drop_col=7 -> col_full one cycle after accept with no RAM access; and clear together with drop_valid in IDLE -> CLEAR entered and drop not accepted.
REQ-043 SHALL check: reset asserted during WRITE of a column-5 drop -> ram_wren=0 on the next cycle, and the sweep restarts at address 0 after release.

Source files
------------

// File: rtl/piece_dropper.sv
// Drop-a-piece controller for a 7x7 column-stacking board held in an external
// synchronous RAM: wipes the board, scans a column bottom-up and writes the piece.
//
// state  | meaning
// CLEAR  | sweep 00 into every board cell, address 0..48
// IDLE   | waiting for a drop or a clear request
// READ   | present address of the scan row in the target column
// CHECK  | RAM data for the scan row is back; decide write / next row / reject
// WRITE  | write current_player into the landing cell
// DONE   | report landing row, hand the turn to the other player
// REJECT | column full or column index out of range
module piece_dropper #(
  parameter int ROWS = 7,
  parameter int COLS = 7
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       drop_valid,
  input  logic [2:0] drop_col,
  output logic       drop_ready,
  output logic [5:0] ram_address,
  output logic [1:0] ram_data,
  output logic       ram_wren,
  input  logic [1:0] ram_q,
  output logic [1:0] current_player,
  output logic       done,
  output logic [2:0] piece_row,
  output logic       col_full,
  output logic [5:0] move_count,
  output logic       board_full
);

  localparam logic [5:0] LAST_CELL = 6'(ROWS * COLS - 1);
  localparam logic [2:0] TOP_ROW   = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL  = 3'(COLS - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_DONE,
    S_REJECT
  } state_t;

  state_t     state, state_next;
  logic [5:0] sweep;
  logic [2:0] row;
  logic [2:0] col;
  logic [5:0] scan_addr;

  assign scan_addr  = 6'(row) * 6'd7 + 6'(col);
  assign board_full = (move_count == 6'd49);

  always_ff @(posedge Clk) begin
    if (reset) begin
      state          <= S_CLEAR;
      sweep          <= '0;
      row            <= '0;
      col            <= '0;
      current_player <= 2'b01;
      move_count     <= '0;
      piece_row      <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_CLEAR: sweep <= sweep + 6'd1;
        S_IDLE: begin
          if (clear) begin
            sweep          <= '0;
            current_player <= 2'b01;
            move_count     <= '0;
            piece_row      <= '0;
          end else if (drop_valid) begin
            col <= drop_col;
            row <= '0;
          end
        end
        S_CHECK: begin
          if (ram_q != 2'b00 && row != TOP_ROW) row <= row + 3'd1;
        end
        // Results become visible during DONE, while the done pulse is high.
        S_WRITE: begin
          piece_row      <= row;
          current_player <= ~current_player;
          move_count     <= move_count + 6'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    ram_address = '0;
    ram_data    = 2'b00;
    ram_wren    = 1'b0;
    done        = 1'b0;
    col_full    = 1'b0;
    drop_ready  = 1'b0;
    case (state)
      S_CLEAR: begin
        ram_wren    = 1'b1;
        ram_address = sweep;
        if (sweep == LAST_CELL) state_next = S_IDLE;
      end
      S_IDLE: begin
        drop_ready = 1'b1;
        if (clear)           state_next = S_CLEAR;
        else if (drop_valid) state_next = (drop_col > LAST_COL) ? S_REJECT : S_READ;
      end
      S_READ: begin
        ram_address = scan_addr;
        state_next  = S_CHECK;
      end
      S_CHECK: begin
        if (ram_q == 2'b00)      state_next = S_WRITE;
        else if (row == TOP_ROW) state_next = S_REJECT;
        else                     state_next = S_READ;
      end
      S_WRITE: begin
        ram_address = scan_addr;
        ram_data    = current_player;
        ram_wren    = 1'b1;
        state_next  = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_REJECT: begin
        col_full   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_CLEAR;
    endcase
    // Reset must silence the RAM port immediately, not one edge later.
    if (reset) begin
      ram_address = '0;
      ram_data    = 2'b00;
      ram_wren    = 1'b0;
      done        = 1'b0;
      col_full    = 1'b0;
      drop_ready  = 1'b0;
    end
  end

endmodule

// File: tb/tb_piece_dropper.sv
// Self-checking bench for piece_dropper: a column-height board model schedules
// the expected RAM traffic and status per cycle; directed drops pin it with literals.
module tb_piece_dropper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       drop_valid = 1'b0;
  logic [2:0] drop_col = 3'd0;
  logic       drop_ready;
  logic [5:0] ram_address;
  logic [1:0] ram_data;
  logic       ram_wren;
  logic [1:0] ram_q = 2'b00;
  logic [1:0] current_player;
  logic       done;
  logic [2:0] piece_row;
  logic       col_full;
  logic [5:0] move_count;
  logic       board_full;

  piece_dropper #(.ROWS(7), .COLS(7)) dut (
    .Clk(clk), .reset(reset), .clear(clear), .drop_valid(drop_valid),
    .drop_col(drop_col), .drop_ready(drop_ready), .ram_address(ram_address),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .current_player(current_player), .done(done), .piece_row(piece_row),
    .col_full(col_full), .move_count(move_count), .board_full(board_full)
  );

  always #5 clk = ~clk;

  // Board RAM with one-cycle registered read.
  logic [1:0] mem [49];
  always @(posedge clk) begin
    if (ram_wren && ram_address < 6'd49) mem[ram_address] <= ram_data;
    ram_q <= (ram_address < 6'd49) ? mem[ram_address] : 2'b00;
  end

  int tests = 0;
  int fails = 0;
  int n = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, n);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_SWEEP, M_IDLE, M_BUSY} mode_t;
  mode_t mode = M_SWEEP;
  int sw_start = 0;
  int m_cp = 1, m_mc = 0, m_pr = 0;
  int heights [7];
  int rd_start = -1, rd_end = -1, rd_col = 0;
  int wr_cyc = -1, wr_addr = 0, wr_data = 0;
  int done_cyc = -1, rej_cyc = -1, busy_end = -1;
  int d_row = 0, d_col = 0;

  always @(posedge clk) begin
    int t, r;
    n++;
    if (reset) begin
      mode = M_SWEEP; sw_start = n;
      m_cp = 1; m_mc = 0; m_pr = 0;
      foreach (heights[i]) heights[i] = 0;
      rd_start = -1; wr_cyc = -1; done_cyc = -1; rej_cyc = -1;
    end else begin
      case (mode)
        M_SWEEP: if (n - 1 == sw_start + 48) mode = M_IDLE;
        M_IDLE: begin
          if (clear) begin
            mode = M_SWEEP; sw_start = n;
            m_cp = 1; m_mc = 0; m_pr = 0;
            foreach (heights[i]) heights[i] = 0;
          end else if (drop_valid) begin
            t = n - 1;
            mode = M_BUSY;
            rd_start = -1; wr_cyc = -1; done_cyc = -1; rej_cyc = -1;
            if (drop_col > 3'd6) begin
              rej_cyc = t + 1; busy_end = t + 2;
            end else begin
              d_col = int'(drop_col); r = heights[d_col];
              rd_start = t + 1; rd_col = d_col;
              if (r >= 7) begin
                rd_end = t + 13; rej_cyc = t + 15; busy_end = t + 16;
              end else begin
                rd_end = t + 1 + 2 * r; wr_cyc = t + 3 + 2 * r;
                done_cyc = t + 4 + 2 * r; busy_end = t + 5 + 2 * r;
                d_row = r; wr_addr = r * 7 + d_col; wr_data = m_cp;
              end
            end
          end
        end
        default: begin
          if (n == done_cyc) begin
            m_pr = d_row; m_cp = 3 - m_cp; m_mc++; heights[d_col]++;
          end
          if (n == busy_end) mode = M_IDLE;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (n >= 1) begin
      if (reset) begin
        chk("rst_wren", int'(ram_wren), 0);
        chk("rst_ready", int'(drop_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_col_full", int'(col_full), 0);
        chk("rst_addr", int'(ram_address), 0);
      end else begin
        chk("ready", int'(drop_ready), int'(mode == M_IDLE));
        chk("wren", int'(ram_wren), int'(mode == M_SWEEP || (mode == M_BUSY && n == wr_cyc)));
        chk("done", int'(done), int'(mode == M_BUSY && n == done_cyc));
        chk("col_full", int'(col_full), int'(mode == M_BUSY && n == rej_cyc));
        if (mode == M_SWEEP) begin
          chk("sweep_addr", int'(ram_address), n - sw_start);
          chk("sweep_data", int'(ram_data), 0);
        end else if (mode == M_BUSY && n == wr_cyc) begin
          chk("write_addr", int'(ram_address), wr_addr);
          chk("write_data", int'(ram_data), wr_data);
        end else if (mode == M_BUSY && rd_start >= 0 && n >= rd_start && n <= rd_end
                     && ((n - rd_start) % 2) == 0) begin
          chk("read_addr", int'(ram_address), ((n - rd_start) / 2) * 7 + rd_col);
        end
      end
      chk("current_player", int'(current_player), m_cp);
      chk("move_count", int'(move_count), m_mc);
      chk("piece_row", int'(piece_row), m_pr);
      chk("board_full", int'(board_full), int'(m_mc == 49));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Accept a drop in the current (IDLE) cycle and advance to cycle T+waitn.
  task automatic drop_wait(input int col, input int waitn);
    drop_valid = 1'b1;
    drop_col = 3'(col);
    tick();
    drop_valid = 1'b0;
    repeat (waitn - 1) tick();
  endtask

  initial begin
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("lit_sweep0_wren", int'(ram_wren), 1);
    chk("lit_sweep0_addr", int'(ram_address), 0);
    repeat (49) tick();
    chk("lit_post_sweep_ready", int'(drop_ready), 1);
    chk("lit_post_sweep_player", int'(current_player), 1);

    // Empty board, column 3.
    drop_valid = 1'b1; drop_col = 3'd3;
    tick(); drop_valid = 1'b0;
    tick(); tick();
    chk("lit_c3_wren", int'(ram_wren), 1);
    chk("lit_c3_addr", int'(ram_address), 3);
    chk("lit_c3_data", int'(ram_data), 1);
    tick();
    chk("lit_c3_done", int'(done), 1);
    chk("lit_c3_row", int'(piece_row), 0);
    chk("lit_c3_player", int'(current_player), 2);
    tick();
    chk("lit_c3_ready", int'(drop_ready), 1);

    // Column 2 stacked three high, fourth piece lands on row 3.
    drop_wait(2, 5); drop_wait(2, 7); drop_wait(2, 9);
    drop_valid = 1'b1; drop_col = 3'd2;
    tick(); drop_valid = 1'b0;
    repeat (6) tick();
    chk("lit_c2_read_addr", int'(ram_address), 23);
    chk("lit_c2_read_wren", int'(ram_wren), 0);
    tick(); tick();
    chk("lit_c2_wren", int'(ram_wren), 1);
    chk("lit_c2_addr", int'(ram_address), 23);
    tick();
    chk("lit_c2_row", int'(piece_row), 3);
    tick();

    // Fill column 0, then overflow it.
    for (int r = 0; r < 7; r++) drop_wait(0, 5 + 2 * r);
    chk("lit_c0_count", int'(move_count), 12);
    drop_valid = 1'b1; drop_col = 3'd0;
    tick(); drop_valid = 1'b0;
    repeat (14) tick();
    chk("lit_c0_full", int'(col_full), 1);
    chk("lit_c0_nowrite", int'(ram_wren), 0);
    tick();
    chk("lit_c0_ready", int'(drop_ready), 1);
    chk("lit_c0_count_kept", int'(move_count), 12);
    chk("lit_c0_player_kept", int'(current_player), 1);

    // Out-of-range column.
    drop_valid = 1'b1; drop_col = 3'd7;
    tick(); drop_valid = 1'b0;
    chk("lit_c7_full", int'(col_full), 1);
    chk("lit_c7_nowrite", int'(ram_wren), 0);
    tick();

    // Clear wins over a simultaneous drop.
    clear = 1'b1; drop_valid = 1'b1; drop_col = 3'd1;
    tick(); clear = 1'b0; drop_valid = 1'b0;
    chk("lit_clr_wren", int'(ram_wren), 1);
    chk("lit_clr_addr", int'(ram_address), 0);
    chk("lit_clr_count", int'(move_count), 0);
    chk("lit_clr_player", int'(current_player), 1);
    repeat (49) tick();
    chk("lit_clr_ready", int'(drop_ready), 1);

    // Reset lands on the WRITE cycle of a column-5 drop.
    drop_valid = 1'b1; drop_col = 3'd5;
    tick(); drop_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("lit_rst_write_wren", int'(ram_wren), 0);
    tick();
    chk("lit_rst_next_wren", int'(ram_wren), 0);
    reset = 1'b0;
    #1;
    chk("lit_rst_sweep_wren", int'(ram_wren), 1);
    chk("lit_rst_sweep_addr", int'(ram_address), 0);
    repeat (49) tick();
    chk("lit_rst_ready", int'(drop_ready), 1);
    drop_wait(5, 5);
    chk("lit_c5_row", int'(piece_row), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
